next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
// - Next-PC generator feeding the PC register: picks NextPC each cycle from
//   sequential, branch, jump, call and return sources.
// - Holds an internal return-address stack (RAS) for Call/Ret.
// - NextPC is combinational from the current inputs and stack state. Stack
//   state updates on the rising CLK edge, in the same cycle the PC register
//   captures NextPC.
// PARAMETERS
// - WIDTH        8      PC / address width in bits
// - DEPTH        4      RAS entries (2..16)
// - TRAP_VECTOR  8'hF0  redirect address on stack error (STACK_ERR_TRAP_EN only)
// PORTS
// - CLK           in   1      clock, rising edge
// - ResetN        in   1      asynchronous, active-low reset
// - CurrentPC     in   WIDTH  current PC register output
// - Stall         in   1      hold PC; no stack change
// - Branch        in   1      conditional branch taken
// - BranchOffset  in   WIDTH  signed two's-complement offset, relative to CurrentPC+1
// - Jump          in   1      absolute jump to JumpTarget
// - Call          in   1      push CurrentPC+1, go to JumpTarget
// - Ret           in   1      pop RAS top into NextPC
// - JumpTarget    in   WIDTH  target for Jump/Call
// - ClearErr      in   1      synchronous clear of sticky error flags
// - NextPC        out  WIDTH  next PC value to the PC register
// - StackDepth    out  5      current RAS occupancy, 0..DEPTH
// - StackOverflow out  1      sticky: Call issued while RAS full
// - StackUnderflow out 1      sticky: Ret issued while RAS empty
// BEHAVIOUR
// - Reset (ResetN=0, async): RAS empty, StackDepth=0, both flags=0.
//   NextPC is forced to 0 while ResetN=0.
// - Priority, highest first: Stall > Ret > Call > Jump > Branch > sequential.
//   Any lower-priority request asserted at the same time is ignored.
// - Stall: NextPC=CurrentPC; RAS and flags unchanged (ClearErr still acts).
// - Sequential: NextPC=CurrentPC+1.
// - Branch: NextPC=CurrentPC+1+BranchOffset.
// - Jump: NextPC=JumpTarget.
// - Call, RAS not full:
//   - NextPC=JumpTarget.
//   - At the edge: push CurrentPC+1; depth+1.
// - Call, RAS full:
//   - NextPC=JumpTarget; no push, contents intact.
//   - StackOverflow set at the edge.
// - Ret, RAS not empty:
//   - NextPC=top entry, combinational and valid in the same cycle.
//   - At the edge: pop; depth-1.
// - Ret, RAS empty:
//   - NextPC=CurrentPC+1; depth stays 0.
//   - StackUnderflow set at the edge.
// - Arithmetic: all address arithmetic is modulo 2^WIDTH.
//   - 8'hFF+1 wraps to 8'h00.
//   - Branch overflow wraps silently.
// - Sticky flags: cleared only by reset or by ClearErr=1 at an edge.
//   A set and ClearErr in the same cycle leave the flag set (set wins).
// - Latency: NextPC has zero cycles of latency. StackDepth and flags reflect a
//   request one edge after it.
// - Async reset mid-operation discards all RAS contents immediately.
// CONFIGURATION
// - STACK_ERR_TRAP_EN defined: an overflowing Call or underflowing Ret drives
//   NextPC=TRAP_VECTOR instead of JumpTarget / CurrentPC+1. Flag behaviour is
//   identical.
// - STACK_ERR_TRAP_EN undefined: the behaviour given above; TRAP_VECTOR unused.
// TESTING
// - Reset:
//   - Stimulus: ResetN=0 with random inputs.
//   - Required: NextPC=0, StackDepth=0, flags=0.
//   - Then ResetN=1, CurrentPC=8'h05, no requests: NextPC=8'h06.
// - Branch and wrap:
//   - CurrentPC=8'h10, Branch=1, BranchOffset=8'hFC -> NextPC=8'h0D.
//   - CurrentPC=8'hFF, no requests -> NextPC=8'h00.
// - Call/Ret round trip:
//   - Call at PC=8'h20 to 8'h80 -> NextPC=8'h80, StackDepth=1.
//   - Later Ret at PC=8'h85 -> NextPC=8'h21, StackDepth=0.
// - Overflow (DEPTH=4):
//   - Stimulus: 5 Calls from PCs 1,2,3,4,5.
//   - Required: StackDepth=4, StackOverflow=1.
//   - 4 Rets then return 5,4,3,2. A 5th Ret gives StackUnderflow=1 and
//     NextPC=CurrentPC+1.
//   - Repeat with STACK_ERR_TRAP_EN defined: 5th Call and 5th Ret give
//     NextPC=8'hF0.
// - Priority and stall:
//   - Stall+Ret+Jump at PC=8'h30, depth 2 -> NextPC=8'h30, depth 2.
//   - Ret+Call -> pop only, depth 1.
//   - Jump+Branch -> NextPC=JumpTarget.
// - ClearErr:
//   - ClearErr=1 with flags set -> both flags 0 next cycle.
//   - ClearErr plus an overflowing Call in the same cycle -> StackOverflow stays 1.

Source files
------------

// File: rtl/next_pc_unit.sv
// Next-PC selector with a return-address stack for Call/Ret.
// Optional macro STACK_ERR_TRAP_EN redirects stack-error Call/Ret to TRAP_VECTOR.
module next_pc_unit #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       DEPTH       = 4,
  parameter logic [WIDTH-1:0]  TRAP_VECTOR = WIDTH'(8'hF0)
) (
  input  logic             CLK,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] CurrentPC,
  input  logic             Stall,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchOffset,
  input  logic             Jump,
  input  logic             Call,
  input  logic             Ret,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             ClearErr,
  output logic [WIDTH-1:0] NextPC,
  output logic [4:0]       StackDepth,
  output logic             StackOverflow,
  output logic             StackUnderflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef STACK_ERR_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    SelSeq,
    SelBranch,
    SelJump,
    SelCall,
    SelRet,
    SelStall
  } sel_e;

  sel_e sel;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [4:0]       depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             stack_full;
  logic             stack_empty;
  logic [PtrW-1:0]  top_idx;
  logic [PtrW-1:0]  push_idx;
  logic [WIDTH-1:0] top_entry;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] branch_pc;
  logic [WIDTH-1:0] err_call_pc;
  logic [WIDTH-1:0] err_ret_pc;
  logic [WIDTH-1:0] pc_sel;

  assign stack_full  = (depth_q == 5'(DEPTH));
  assign stack_empty = (depth_q == 5'd0);
  assign top_idx     = PtrW'(depth_q - 5'd1);
  assign push_idx    = depth_q[PtrW-1:0];
  assign top_entry   = stack_q[top_idx];

  // Address arithmetic wraps modulo 2^WIDTH by truncation.
  assign pc_plus1    = CurrentPC + WIDTH'(1);
  assign branch_pc   = pc_plus1 + BranchOffset;

  assign err_call_pc = TrapEn ? TRAP_VECTOR : JumpTarget;
  assign err_ret_pc  = TrapEn ? TRAP_VECTOR : pc_plus1;

  // Fixed priority: Stall > Ret > Call > Jump > Branch > sequential.
  always_comb begin
    sel = SelSeq;
    if (Stall) begin
      sel = SelStall;
    end else if (Ret) begin
      sel = SelRet;
    end else if (Call) begin
      sel = SelCall;
    end else if (Jump) begin
      sel = SelJump;
    end else if (Branch) begin
      sel = SelBranch;
    end
  end

  always_comb begin
    pc_sel = pc_plus1;
    unique case (sel)
      SelStall:  pc_sel = CurrentPC;
      SelRet:    pc_sel = stack_empty ? err_ret_pc : top_entry;
      SelCall:   pc_sel = stack_full ? err_call_pc : JumpTarget;
      SelJump:   pc_sel = JumpTarget;
      SelBranch: pc_sel = branch_pc;
      default:   pc_sel = pc_plus1;
    endcase
  end

  assign NextPC = ResetN ? pc_sel : '0;

  // Sticky flags: ClearErr drops them unless a new error sets them this cycle.
  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    ovf_d   = ovf_q & ~ClearErr;
    unf_d   = unf_q & ~ClearErr;
    if (sel == SelCall) begin
      if (stack_full) begin
        ovf_d = 1'b1;
      end else begin
        stack_d[push_idx] = pc_plus1;
        depth_d           = depth_q + 5'd1;
      end
    end else if (sel == SelRet) begin
      if (stack_empty) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - 5'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      depth_q <= 5'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign StackDepth     = depth_q;
  assign StackOverflow  = ovf_q;
  assign StackUnderflow = unf_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (WIDTH=8, DEPTH=4).
module tb_next_pc_unit;

`ifdef STACK_ERR_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] current_pc;
  logic       stall;
  logic       branch;
  logic [7:0] branch_offset;
  logic       jump;
  logic       call;
  logic       ret;
  logic [7:0] jump_target;
  logic       clear_err;
  logic [7:0] next_pc;
  logic [4:0] stack_depth;
  logic       stack_overflow;
  logic       stack_underflow;

  int checks = 0;
  int passes = 0;

  next_pc_unit #(
    .WIDTH      (8),
    .DEPTH      (4),
    .TRAP_VECTOR(8'hF0)
  ) dut (
    .CLK           (clk),
    .ResetN        (rst_n),
    .CurrentPC     (current_pc),
    .Stall         (stall),
    .Branch        (branch),
    .BranchOffset  (branch_offset),
    .Jump          (jump),
    .Call          (call),
    .Ret           (ret),
    .JumpTarget    (jump_target),
    .ClearErr      (clear_err),
    .NextPC        (next_pc),
    .StackDepth    (stack_depth),
    .StackOverflow (stack_overflow),
    .StackUnderflow(stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    stall         = 1'b0;
    branch        = 1'b0;
    branch_offset = 8'h00;
    jump          = 1'b0;
    call          = 1'b0;
    ret           = 1'b0;
    jump_target   = 8'h00;
    clear_err     = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    current_pc    = 8'($urandom);
    stall         = 1'b0;
    branch        = 1'($urandom);
    branch_offset = 8'($urandom);
    jump          = 1'($urandom);
    call          = 1'b1;
    ret           = 1'b0;
    jump_target   = 8'($urandom);
    clear_err     = 1'($urandom);
    #2;
    checks++;
    if (next_pc !== 8'h00) $display("FAIL reset_next_pc got=%h exp=00", next_pc);
    else passes++;
    tick();
    checks++;
    if (stack_depth !== 5'd0) $display("FAIL reset_depth got=%0d exp=0", stack_depth);
    else passes++;
    checks++;
    if (stack_overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", stack_overflow);
    else passes++;
    checks++;
    if (stack_underflow !== 1'b0) $display("FAIL reset_unf got=%b exp=0", stack_underflow);
    else passes++;
    idle();
    rst_n      = 1'b1;
    current_pc = 8'h05;
    #1;
    checks++;
    if (next_pc !== 8'h06) $display("FAIL reset_release_seq got=%h exp=06", next_pc);
    else passes++;
    tick();
  endtask

  task automatic test_branch_wrap();
    idle();
    current_pc    = 8'h10;
    branch        = 1'b1;
    branch_offset = 8'hFC;
    #1;
    checks++;
    if (next_pc !== 8'h0D) $display("FAIL branch_back got=%h exp=0d", next_pc);
    else passes++;
    current_pc    = 8'h02;
    branch_offset = 8'hF0;
    #1;
    checks++;
    if (next_pc !== 8'hF3) $display("FAIL branch_wrap got=%h exp=f3", next_pc);
    else passes++;
    idle();
    current_pc = 8'hFF;
    #1;
    checks++;
    if (next_pc !== 8'h00) $display("FAIL seq_wrap got=%h exp=00", next_pc);
    else passes++;
    tick();
  endtask

  task automatic test_call_ret();
    idle();
    current_pc  = 8'h20;
    call        = 1'b1;
    jump_target = 8'h80;
    #1;
    checks++;
    if (next_pc !== 8'h80) $display("FAIL call_target got=%h exp=80", next_pc);
    else passes++;
    tick();
    checks++;
    if (stack_depth !== 5'd1) $display("FAIL call_depth got=%0d exp=1", stack_depth);
    else passes++;
    idle();
    current_pc = 8'h80;
    tick();
    current_pc = 8'h85;
    ret        = 1'b1;
    #1;
    checks++;
    if (next_pc !== 8'h21) $display("FAIL ret_addr got=%h exp=21", next_pc);
    else passes++;
    tick();
    checks++;
    if (stack_depth !== 5'd0) $display("FAIL ret_depth got=%0d exp=0", stack_depth);
    else passes++;
    idle();
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 1; i <= 5; i++) begin
      idle();
      current_pc  = 8'(i);
      call        = 1'b1;
      jump_target = 8'h40;
      #1;
      exp = (i == 5 && Trap) ? 8'hF0 : 8'h40;
      checks++;
      if (next_pc !== exp) $display("FAIL ovf_call%0d got=%h exp=%h", i, next_pc, exp);
      else passes++;
      tick();
    end
    checks++;
    if (stack_depth !== 5'd4) $display("FAIL ovf_depth got=%0d exp=4", stack_depth);
    else passes++;
    checks++;
    if (stack_overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", stack_overflow);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      idle();
      current_pc = 8'h50;
      ret        = 1'b1;
      #1;
      exp = 8'(5 - i);
      checks++;
      if (next_pc !== exp) $display("FAIL ovf_ret%0d got=%h exp=%h", i, next_pc, exp);
      else passes++;
      tick();
    end
    checks++;
    if (stack_underflow !== 1'b0) $display("FAIL unf_early got=%b exp=0", stack_underflow);
    else passes++;
    idle();
    current_pc = 8'h50;
    ret        = 1'b1;
    #1;
    exp = Trap ? 8'hF0 : 8'h51;
    checks++;
    if (next_pc !== exp) $display("FAIL unf_ret got=%h exp=%h", next_pc, exp);
    else passes++;
    tick();
    checks++;
    if (stack_underflow !== 1'b1) $display("FAIL unf_flag got=%b exp=1", stack_underflow);
    else passes++;
    checks++;
    if (stack_depth !== 5'd0) $display("FAIL unf_depth got=%0d exp=0", stack_depth);
    else passes++;
    checks++;
    if (stack_overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", stack_overflow);
    else passes++;
    idle();
  endtask

  task automatic test_clear_err();
    idle();
    clear_err = 1'b1;
    tick();
    checks++;
    if (stack_overflow !== 1'b0) $display("FAIL clr_ovf got=%b exp=0", stack_overflow);
    else passes++;
    checks++;
    if (stack_underflow !== 1'b0) $display("FAIL clr_unf got=%b exp=0", stack_underflow);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      idle();
      current_pc  = 8'h60 + 8'(i);
      call        = 1'b1;
      jump_target = 8'h61 + 8'(i);
      tick();
    end
    idle();
    current_pc  = 8'h70;
    call        = 1'b1;
    clear_err   = 1'b1;
    jump_target = 8'h44;
    tick();
    checks++;
    if (stack_overflow !== 1'b1) $display("FAIL clr_set_wins got=%b exp=1", stack_overflow);
    else passes++;
    checks++;
    if (stack_depth !== 5'd4) $display("FAIL clr_full_depth got=%0d exp=4", stack_depth);
    else passes++;
    idle();
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    idle();
    current_pc = 8'h10;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stack_depth !== 5'd0) $display("FAIL async_depth got=%0d exp=0", stack_depth);
    else passes++;
    checks++;
    if (stack_overflow !== 1'b0) $display("FAIL async_ovf got=%b exp=0", stack_overflow);
    else passes++;
    #1;
    rst_n = 1'b1;
    ret   = 1'b1;
    #1;
    exp = Trap ? 8'hF0 : 8'h11;
    checks++;
    if (next_pc !== exp) $display("FAIL async_empty_ret got=%h exp=%h", next_pc, exp);
    else passes++;
    idle();
    tick();
    clear_err = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_priority();
    idle();
    current_pc  = 8'h10;
    call        = 1'b1;
    jump_target = 8'h30;
    tick();
    current_pc = 8'h11;
    tick();
    checks++;
    if (stack_depth !== 5'd2) $display("FAIL prio_setup_depth got=%0d exp=2", stack_depth);
    else passes++;
    idle();
    current_pc  = 8'h30;
    stall       = 1'b1;
    ret         = 1'b1;
    jump        = 1'b1;
    jump_target = 8'h55;
    #1;
    checks++;
    if (next_pc !== 8'h30) $display("FAIL stall_pc got=%h exp=30", next_pc);
    else passes++;
    tick();
    checks++;
    if (stack_depth !== 5'd2) $display("FAIL stall_depth got=%0d exp=2", stack_depth);
    else passes++;
    idle();
    current_pc  = 8'h31;
    ret         = 1'b1;
    call        = 1'b1;
    jump_target = 8'h99;
    #1;
    checks++;
    if (next_pc !== 8'h12) $display("FAIL ret_over_call got=%h exp=12", next_pc);
    else passes++;
    tick();
    checks++;
    if (stack_depth !== 5'd1) $display("FAIL ret_over_call_depth got=%0d exp=1", stack_depth);
    else passes++;
    idle();
    current_pc    = 8'h40;
    jump          = 1'b1;
    branch        = 1'b1;
    branch_offset = 8'h05;
    jump_target   = 8'h77;
    #1;
    checks++;
    if (next_pc !== 8'h77) $display("FAIL jump_over_branch got=%h exp=77", next_pc);
    else passes++;
    tick();
    checks++;
    if (stack_depth !== 5'd1) $display("FAIL jump_depth got=%0d exp=1", stack_depth);
    else passes++;
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    current_pc  = 8'h90;
    call        = 1'b1;
    jump_target = 8'hA0;
    tick();
    idle();
    current_pc = 8'hA0;
    ret        = 1'b1;
    #1;
    checks++;
    if (next_pc !== 8'h91) $display("FAIL b2b_ret got=%h exp=91", next_pc);
    else passes++;
    tick();
    current_pc = 8'h91;
    #1;
    checks++;
    if (next_pc !== 8'h11) $display("FAIL b2b_ret2 got=%h exp=11", next_pc);
    else passes++;
    tick();
    checks++;
    if (stack_depth !== 5'd0) $display("FAIL b2b_depth got=%0d exp=0", stack_depth);
    else passes++;
    checks++;
    if (stack_underflow !== 1'b0) $display("FAIL b2b_unf got=%b exp=0", stack_underflow);
    else passes++;
    idle();
  endtask

  initial begin
    idle();
    rst_n      = 1'b0;
    current_pc = 8'h00;
    test_reset();
    test_branch_wrap();
    test_call_ret();
    test_overflow();
    test_clear_err();
    test_async_reset();
    test_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
